// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter sharing one Avalon-style slave port.
// Ports: clk/reset, m0_* (fetch), m1_* (load/store), s_* (slave), bus_error.
module mips_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,
    output logic        bus_error
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        req0, req1;
    logic        gsel;
    logic        greq;
    logic [7:0]  cnt_inc;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Round-robin pick: on a tie the master that did not go last wins.
    function automatic state_e pick(
        input logic r0,
        input logic r1,
        input logic lst
    );
        state_e s;
        s = IDLE;
        if (r0 && !r1) begin
            s = GRANT0;
        end else if (r1 && !r0) begin
            s = GRANT1;
        end else if (r0 && r1) begin
            s = lst ? GRANT0 : GRANT1;
        end
        return s;
    endfunction

    assign gsel    = (state_q == GRANT1);
    assign greq    = gsel ? req1 : req0;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d   = 8'd0;
                state_d = pick(req0, req1, last_q);
            end
            GRANT0, GRANT1: begin
                if (!greq) begin
                    // Master withdrew: abandon without touching priority.
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (!s_waitrequest) begin
                    // Completion: re-arbitrate now so there is no bubble.
                    last_d  = gsel;
                    cnt_d   = 8'd0;
                    state_d = pick(req0, req1, gsel);
                end else if (cnt_inc >= TO) begin
                    // Hung slave: flag it and demote the stuck master.
                    err_d   = 1'b1;
                    last_d  = gsel;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        s_address      = 32'd0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = 32'd0;
        s_byteenable   = 4'd0;
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        if (reset) begin
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b1;
        end else begin
            unique case (state_q)
                GRANT0: begin
                    s_address      = m0_address;
                    s_read         = m0_read;
                    s_write        = m0_write;
                    s_writedata    = m0_writedata;
                    s_byteenable   = m0_byteenable;
                    m0_waitrequest = s_waitrequest;
                end
                GRANT1: begin
                    s_address      = m1_address;
                    s_read         = m1_read;
                    s_write        = m1_write;
                    s_writedata    = m1_writedata;
                    s_byteenable   = m1_byteenable;
                    m1_waitrequest = s_waitrequest;
                end
                default: begin
                end
            endcase
        end
    end

    assign m_readdata = s_readdata;
    assign bus_error  = err_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter with directed vectors.
// A negedge monitor checks every completed slave transaction.
module tb_mips_bus_arbiter;

    localparam logic [31:0] RD_KEY = 32'h5A5A_1234;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic        bus_error;

    always #5 clk = ~clk;

    // Slave model: read data is a fixed scramble of the address.
    assign s_readdata = s_address ^ RD_KEY;

    mips_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_waitrequest (m1_waitrequest),
        .m_readdata     (m_readdata),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest),
        .bus_error      (bus_error)
    );

    typedef struct {
        logic        gid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_gid;
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic g, input logic we,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        exp_t e;
        e.gid   = g;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        e.be    = be;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a completed transfer is a slave command without stall.
    always @(negedge clk) begin
        if (!reset && (s_read || s_write) && !s_waitrequest) begin
            mon_gid = ((m0_read || m0_write) && !m0_waitrequest) ? 1'b0 : 1'b1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got addr %h expected none",
                         s_address);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_gid", 32'(mon_gid), 32'(mon_e.gid));
                chk("sb_addr", s_address, mon_e.addr);
                chk("sb_we", 32'(s_write), 32'(mon_e.we));
                if (mon_e.we) begin
                    chk("sb_wdata", s_writedata, mon_e.wdata);
                    chk("sb_be", 32'(s_byteenable), 32'(mon_e.be));
                end else begin
                    chk("sb_rdata", m_readdata, mon_e.addr ^ RD_KEY);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        m0_address = '0; m0_read = 0; m0_write = 0;
        m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0;

        // Reset held two cycles
        @(negedge clk);
        chk("rst_sread", 32'(s_read), 0);
        chk("rst_wait0", 32'(m0_waitrequest), 1);
        chk("rst_wait1", 32'(m1_waitrequest), 1);
        step();
        @(negedge clk);
        chk("rst_err", 32'(bus_error), 0);

        // A: single m0 read, one-cycle arbitration latency
        step();
        reset = 1'b0;
        m0_read = 1; m0_address = 32'hBFC0_0000; m0_byteenable = 4'hF;
        push(0, 0, 32'hBFC0_0000, 0, 4'hF);
        @(negedge clk);
        chk("A_c1_wait0", 32'(m0_waitrequest), 1);
        chk("A_c1_sread", 32'(s_read), 0);
        step();
        @(negedge clk);
        chk("A_c2_sread", 32'(s_read), 1);
        chk("A_c2_addr", s_address, 32'hBFC0_0000);
        chk("A_c2_wait0", 32'(m0_waitrequest), 0);
        chk("A_c2_rdata", m_readdata, 32'hE59A_1234);
        step();
        m0_read = 0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("A_idle_wait0", 32'(m0_waitrequest), 0);
        chk("A_idle_wait1", 32'(m1_waitrequest), 0);

        // B: simultaneous after reset, m0 first then m1 back-to-back
        step();
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0;
        m0_read = 1; m0_address = 32'h0040_0000;
        m1_write = 1; m1_address = 32'h1000_0000;
        m1_writedata = 32'h0000_0FF0; m1_byteenable = 4'hF;
        push(0, 0, 32'h0040_0000, 0, 4'hF);
        push(1, 1, 32'h1000_0000, 32'h0000_0FF0, 4'hF);
        @(negedge clk);
        chk("B_c1_wait0", 32'(m0_waitrequest), 1);
        chk("B_c1_wait1", 32'(m1_waitrequest), 1);
        step();
        @(negedge clk);
        chk("B_c2_sread", 32'(s_read), 1);
        chk("B_c2_wait1", 32'(m1_waitrequest), 1);
        step();
        m0_read = 0;
        @(negedge clk);
        chk("B_c3_swrite", 32'(s_write), 1);
        chk("B_c3_wdata", s_writedata, 32'h0000_0FF0);
        chk("B_c3_be", 32'(s_byteenable), 32'hF);
        step();
        m1_write = 0;
        @(negedge clk);
        step();
        @(negedge clk);

        // C: both hold requests, grants alternate 0,1,0,1,0,1
        step();
        m0_read = 1; m0_address = 32'h0040_0010; m0_byteenable = 4'hF;
        m1_write = 1; m1_address = 32'h1000_0040;
        m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'h3;
        for (int i = 0; i < 3; i++) begin
            push(0, 0, 32'h0040_0010, 0, 4'hF);
            push(1, 1, 32'h1000_0040, 32'hDEAD_BEEF, 4'h3);
        end
        @(negedge clk);
        chk("C_idle_wait0", 32'(m0_waitrequest), 1);
        for (int i = 1; i <= 6; i++) begin
            step();
            @(negedge clk);
            chk("C_wait0", 32'(m0_waitrequest), (i % 2 == 1) ? 0 : 1);
            chk("C_wait1", 32'(m1_waitrequest), (i % 2 == 1) ? 1 : 0);
        end
        step();
        m0_read = 0; m1_write = 0;
        @(negedge clk);
        step();
        @(negedge clk);

        // D: m1 read stalled three cycles, completes on the fourth
        step();
        m1_read = 1; m1_address = 32'h1000_0080; s_waitrequest = 1;
        push(1, 0, 32'h1000_0080, 0, 4'h3);
        @(negedge clk);
        chk("D_idle_sread", 32'(s_read), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("D_stall_wait1", 32'(m1_waitrequest), 1);
            chk("D_stall_sread", 32'(s_read), 1);
            chk("D_stall_err", 32'(bus_error), 0);
        end
        step();
        s_waitrequest = 0;
        @(negedge clk);
        chk("D_done_wait1", 32'(m1_waitrequest), 0);
        chk("D_done_err", 32'(bus_error), 0);
        step();
        m1_read = 0;
        @(negedge clk);
        step();
        @(negedge clk);

        // E: m0 hangs for TIMEOUT=4 cycles, pending m1 then served
        step();
        s_waitrequest = 1;
        m0_read = 1; m0_address = 32'h0040_0020;
        m1_write = 1; m1_address = 32'h1000_0100;
        m1_writedata = 32'h1234_5678; m1_byteenable = 4'hF;
        push(1, 1, 32'h1000_0100, 32'h1234_5678, 4'hF);
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            step();
            @(negedge clk);
            chk("E_stall_sread", 32'(s_read), 1);
            chk("E_stall_err", 32'(bus_error), 0);
        end
        step();
        @(negedge clk);
        chk("E_to_err", 32'(bus_error), 1);
        chk("E_to_sread", 32'(s_read), 0);
        chk("E_to_wait0", 32'(m0_waitrequest), 1);
        chk("E_to_wait1", 32'(m1_waitrequest), 1);
        step();
        s_waitrequest = 0;
        @(negedge clk);
        chk("E_g1_swrite", 32'(s_write), 1);
        chk("E_g1_wait0", 32'(m0_waitrequest), 1);
        step();
        m0_read = 0; m1_write = 0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("E_sticky_err", 32'(bus_error), 1);

        // F: reset in the middle of a stalled m1 write
        step();
        s_waitrequest = 1;
        m1_write = 1; m1_address = 32'h1000_0200;
        m1_writedata = 32'hA5A5_A5A5; m1_byteenable = 4'hC;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("F_g1_swrite", 32'(s_write), 1);
        step();
        reset = 1;
        @(negedge clk);
        chk("F_rst_swrite", 32'(s_write), 0);
        chk("F_rst_saddr", s_address, 0);
        chk("F_rst_wdata", s_writedata, 0);
        chk("F_rst_be", 32'(s_byteenable), 0);
        chk("F_rst_wait0", 32'(m0_waitrequest), 1);
        chk("F_rst_wait1", 32'(m1_waitrequest), 1);
        step();
        reset = 0; s_waitrequest = 0;
        m0_read = 1; m0_address = 32'h0040_0030; m0_byteenable = 4'hF;
        push(0, 0, 32'h0040_0030, 0, 4'hF);
        push(1, 1, 32'h1000_0200, 32'hA5A5_A5A5, 4'hC);
        @(negedge clk);
        chk("F_post_err", 32'(bus_error), 0);
        chk("F_post_wait0", 32'(m0_waitrequest), 1);
        step();
        @(negedge clk);
        chk("F_g0_sread", 32'(s_read), 1);
        chk("F_g0_wait1", 32'(m1_waitrequest), 1);
        step();
        m0_read = 0;
        @(negedge clk);
        chk("F_g1_swrite2", 32'(s_write), 1);
        step();
        m1_write = 0;
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU memory bus (address, read, write, writedata, byteenable, readdata, waitrequest).
- Lets the instruction-fetch master (m0) and the load/store master (m1) share the single RAM/slave port.
- Round-robin grant, one transaction at a time; waitrequest back-pressure passes through to the granted master.
- A hung-slave timeout counter raises a sticky error flag.

Parameters:
- TIMEOUT, 255: maximum consecutive slave waitrequest cycles in one transaction before bus_error sets (8-bit counter, 1..255).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- m0_address  input  32  instruction master byte address
- m0_read  input  1  instruction master read request
- m0_write  input  1  instruction master write request
- m0_writedata  input  32  instruction master write data
- m0_byteenable  input  4  instruction master byte lanes
- m0_waitrequest  output  1  stall to instruction master
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable  input  32/1/1/32/4  data master, same meanings as m0
- m1_waitrequest  output  1  stall to data master
- m_readdata  output  32  slave readdata broadcast to both masters
- s_address  output  32  to slave
- s_read  output  1  to slave
- s_write  output  1  to slave
- s_writedata  output  32  to slave
- s_byteenable  output  4  to slave
- s_readdata  input  32  from slave
- s_waitrequest  input  1  from slave
- bus_error  output  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset is sampled at the posedge of clk only.
- Reset, including mid-transaction:
  - state <= IDLE, last_grant <= 1 (so m0 wins the first tie), wait_cnt <= 0, bus_error <= 0.
  - While reset is high: s_read = s_write = 0, s_address = s_writedata = 0, s_byteenable = 0.
  - While reset is high: m0_waitrequest = m1_waitrequest = 1.
  - Any in-flight transaction is abandoned. It is not replayed.
- Request definition: reqN = mN_read | mN_write. If a master asserts read and write together, it is forwarded unchanged; the slave behaviour is undefined.
- States: IDLE, GRANT0, GRANT1 (registered).
- IDLE transitions:
  - Only req0 -> GRANT0. Only req1 -> GRANT1.
  - Both -> the master other than last_grant.
  - Neither -> stay in IDLE.
  - In IDLE, no slave command is issued. Every requesting master sees waitrequest = 1. Arbitration latency is therefore 1 cycle.
- GRANTn behaviour:
  - s_* = mn_* combinationally.
  - mn_waitrequest = s_waitrequest. The other master's waitrequest = 1 if it is requesting, else 0.
- Completion: a transaction completes on the first GRANTn cycle with reqn = 1 and s_waitrequest = 0. On that edge:
  - last_grant <= n, wait_cnt <= 0.
  - Next state is chosen by the IDLE rules using the current reqs, with n treated as last. This allows back-to-back grants with no IDLE bubble.
- Request withdrawal: if reqn drops while in GRANTn with no completion, go to IDLE and leave last_grant unchanged.
- m_readdata = s_readdata in all states. It is valid for the granted master in the completion cycle of a read.
- Timeout counting:
  - In GRANTn with reqn = 1 and s_waitrequest = 1: wait_cnt increments, saturating at 255.
  - When wait_cnt reaches TIMEOUT: bus_error <= 1, sticky until reset. The state returns to IDLE and last_grant <= n (the hung master loses priority).
- Idle outputs: with no request, both m*_waitrequest = 0.

Test Plan:
- Reset held 2 cycles, then m0_read=1, address 32'hBFC00000, slave waitrequest=0 -> cycle 1 m0_waitrequest=1, s_read=0; cycle 2 s_read=1, s_address=32'hBFC00000, m0_waitrequest=0, m_readdata equals slave data.
- m0_read and m1_write asserted together from IDLE after reset -> m0 granted first (1 transaction), then m1 granted on the next cycle with no IDLE gap; s_writedata=m1_writedata=32'h00000FF0, s_byteenable=4'hF.
- Both masters hold requests continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; the non-granted master's waitrequest stays 1.
- m1 granted and slave holds waitrequest=1 for 3 cycles -> m1_waitrequest=1 for those 3 cycles, completes on the 4th; bus_error stays 0.
- TIMEOUT=4 and slave waitrequest stuck at 1 during an m0 read -> bus_error=1 after 4 stalled cycles, state returns to IDLE, pending m1 granted next, bus_error stays 1 until reset.
- Reset asserted mid-GRANT1 with waitrequest=1 -> next cycle s_write=0, both m*_waitrequest=1, bus_error=0; after release m0 wins a simultaneous request.
